// File: rtl/csr_trap_pkg.sv
// Shared constants for the machine-mode CSR / trap unit: CSR addresses, field
// positions, cause codes, the CSR funct3 encoding and the WFI state machine.
package csr_trap_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam int MS_MIE      = 3;
   localparam int MS_MPIE     = 7;
   localparam int MS_MPP_LO   = 11;
   localparam int MS_MPP_HI   = 12;
   localparam int IE_MTI      = 7;
   localparam int IE_MEI      = 11;
   localparam int IE_LOC_BASE = 16;

   localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;

   localparam logic [4:0] CAUSE_MTI      = 5'd7;
   localparam logic [4:0] CAUSE_MEI      = 5'd11;
   localparam logic [4:0] CAUSE_LOC_BASE = 5'd16;

   typedef enum logic [2:0] {
      CSR_RW  = 3'b001,
      CSR_RS  = 3'b010,
      CSR_RC  = 3'b011,
      CSR_RWI = 3'b101,
      CSR_RSI = 3'b110,
      CSR_RCI = 3'b111
   } csr_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } fsm_state_e;

   // Writable bits of mie: MTIE, MEIE and one enable per local interrupt.
   function automatic logic [31:0] mie_mask(input int n);
      return (((32'd1 << n) - 32'd1) << IE_LOC_BASE) | 32'h0000_0880;
   endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Fixed-priority interrupt arbiter: external > timer > local (lowest index wins).
module csr_irq_arb
   import csr_trap_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  logic               ext_pend,
   input  logic               tmr_pend,
   input  logic [NUM_IRQ-1:0] loc_pend,
   output logic               pending,
   output logic [4:0]         cause
);

   always_comb begin
      pending = ext_pend | tmr_pend | (|loc_pend);
      cause   = 5'd0;
      // Descending scan so the lowest pending index is the last to assign.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (loc_pend[i]) cause = CAUSE_LOC_BASE + 5'(i);
      end
      if (tmr_pend) cause = CAUSE_MTI;
      if (ext_pend) cause = CAUSE_MEI;
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap entry, mret return, WFI wait state
// and mcycle/minstret counters. Redirect pulses are registered one cycle after.
module csr_trap_unit
   import csr_trap_pkg::*;
#(
   parameter int          NUM_IRQ   = 4,
   parameter int          CNT_W     = 64,
   parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_we,
   input  logic [2:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   input  logic               mret,
   input  logic               wfi,
   input  logic [31:0]        pc,
   input  logic               stall,
   input  logic               retire,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               ext_irq,
   input  logic               timer_irq,
   output logic [31:0]        csr_rdata,
   output logic               trap_taken,
   output logic               ret_taken,
   output logic [31:0]        trap_pc,
   output logic [31:0]        ret_pc,
   output logic               wfi_stall,
   output fsm_state_e         fsm_state
);

   localparam logic [31:0] MIE_MASK = mie_mask(NUM_IRQ);
   localparam bit          HI_EN    = (CNT_W == 64);

   logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q;
   logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
   logic [63:0] mcycle_inc, minstret_inc;
   logic [31:0] mip_val, wr_val, tvec_base, trap_target;
   logic [4:0]  cause;
   logic        pending, wr_ok, csr_wr, trap_now, ret_now, inst_inc;
   logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

   always_comb begin
      mip_val         = 32'd0;
      mip_val[IE_MTI] = timer_irq;
      mip_val[IE_MEI] = ext_irq;
      for (int i = 0; i < NUM_IRQ; i++) mip_val[IE_LOC_BASE+i] = irq[i];
   end

   csr_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
      .ext_pend (mie_q[IE_MEI] & ext_irq),
      .tmr_pend (mie_q[IE_MTI] & timer_irq),
      .loc_pend (mie_q[IE_LOC_BASE +: NUM_IRQ] & irq),
      .pending  (pending),
      .cause    (cause)
   );

   always_comb begin
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus_q;
         CSR_MIE:       csr_rdata = mie_q;
         CSR_MTVEC:     csr_rdata = mtvec_q & ~32'h2;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MIP:       csr_rdata = mip_val;
         CSR_MCYCLE:    csr_rdata = mcycle_lo;
         CSR_MCYCLEH:   csr_rdata = HI_EN ? mcycle_hi : 32'd0;
         CSR_MINSTRET:  csr_rdata = minstret_lo;
         CSR_MINSTRETH: csr_rdata = HI_EN ? minstret_hi : 32'd0;
         default:       csr_rdata = 32'd0;
      endcase
   end

   // Set/clear forms with a zero operand are reads only and must not write.
   always_comb begin
      wr_val = csr_wdata;
      wr_ok  = 1'b0;
      case (csr_op_e'(csr_op))
         CSR_RW, CSR_RWI: begin wr_val = csr_wdata;              wr_ok = 1'b1;       end
         CSR_RS, CSR_RSI: begin wr_val = csr_rdata | csr_wdata;  wr_ok = |csr_wdata; end
         CSR_RC, CSR_RCI: begin wr_val = csr_rdata & ~csr_wdata; wr_ok = |csr_wdata; end
         default:         begin wr_val = csr_wdata;              wr_ok = 1'b0;       end
      endcase
   end

   assign trap_now  = pending & mstatus_q[MS_MIE] & ~stall;
   assign ret_now   = mret & ~stall & ~trap_now;
   assign csr_wr    = csr_we & ~stall & ~trap_now & wr_ok;
   assign tvec_base = {mtvec_q[31:2], 2'b00};
   assign trap_target = mtvec_q[0] ? tvec_base + {25'd0, cause, 2'b00} : tvec_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_q <= 32'd0;
         mie_q     <= 32'd0;
         mtvec_q   <= MTVEC_RST;
         mepc_q    <= 32'd0;
         mcause_q  <= 32'd0;
      end else if (trap_now) begin
         mepc_q                         <= pc & ~32'h3;
         mcause_q                       <= {1'b1, 26'd0, cause};
         mstatus_q[MS_MPIE]             <= mstatus_q[MS_MIE];
         mstatus_q[MS_MIE]              <= 1'b0;
         mstatus_q[MS_MPP_HI:MS_MPP_LO] <= 2'b11;
      end else begin
         if (ret_now) begin
            mstatus_q[MS_MIE]              <= mstatus_q[MS_MPIE];
            mstatus_q[MS_MPIE]             <= 1'b1;
            mstatus_q[MS_MPP_HI:MS_MPP_LO] <= 2'b11;
         end
         if (csr_wr) begin
            case (csr_addr)
               CSR_MSTATUS: mstatus_q <= wr_val & MSTATUS_MASK;
               CSR_MIE:     mie_q     <= wr_val & MIE_MASK;
               CSR_MTVEC:   mtvec_q   <= wr_val & ~32'h2;
               CSR_MEPC:    mepc_q    <= wr_val & ~32'h3;
               CSR_MCAUSE:  mcause_q  <= wr_val;
               default:     ;
            endcase
         end
      end
   end

   assign wr_cyc_lo    = csr_wr & (csr_addr == CSR_MCYCLE);
   assign wr_cyc_hi    = csr_wr & (csr_addr == CSR_MCYCLEH) & HI_EN;
   assign wr_ins_lo    = csr_wr & (csr_addr == CSR_MINSTRET);
   assign wr_ins_hi    = csr_wr & (csr_addr == CSR_MINSTRETH) & HI_EN;
   assign inst_inc     = retire & ~stall;
   assign mcycle_inc   = {mcycle_hi, mcycle_lo} + 64'd1;
   assign minstret_inc = {minstret_hi, minstret_lo} + 64'd1;

   // A write to either half freezes the other half for that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_lo   <= 32'd0;
         mcycle_hi   <= 32'd0;
         minstret_lo <= 32'd0;
         minstret_hi <= 32'd0;
      end else begin
         if (wr_cyc_lo)       mcycle_lo <= wr_val;
         else if (!wr_cyc_hi) mcycle_lo <= mcycle_inc[31:0];
         if (wr_cyc_hi)                 mcycle_hi <= wr_val;
         else if (!wr_cyc_lo && HI_EN)  mcycle_hi <= mcycle_inc[63:32];

         if (wr_ins_lo)                    minstret_lo <= wr_val;
         else if (!wr_ins_hi && inst_inc)  minstret_lo <= minstret_inc[31:0];
         if (wr_ins_hi)                             minstret_hi <= wr_val;
         else if (!wr_ins_lo && inst_inc && HI_EN)  minstret_hi <= minstret_inc[63:32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_state  <= ST_RUN;
         wfi_stall  <= 1'b0;
         trap_taken <= 1'b0;
         ret_taken  <= 1'b0;
         trap_pc    <= 32'd0;
         ret_pc     <= 32'd0;
      end else begin
         trap_taken <= trap_now;
         ret_taken  <= ret_now;
         if (trap_now) trap_pc <= trap_target;
         if (ret_now)  ret_pc  <= mepc_q;
         case (fsm_state)
            ST_RUN: begin
               if (wfi && !stall && !pending) begin
                  fsm_state <= ST_WAIT;
                  wfi_stall <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (pending) begin
                  fsm_state <= ST_RUN;
                  wfi_stall <= 1'b0;
               end
            end
            default: begin
               fsm_state <= ST_RUN;
               wfi_stall <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: a CSR read/write vector table followed by
// hand-written trap, mret, wfi, counter and reset sequences.
module tb_csr_trap_unit;
   import csr_trap_pkg::*;

   logic        clk, rst, csr_we, mret, wfi, stall, retire, ext_irq, timer_irq;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, pc;
   logic [3:0]  irq;
   logic [31:0] csr_rdata, trap_pc, ret_pc;
   logic        trap_taken, ret_taken, wfi_stall;
   fsm_state_e  fsm_state;
   logic [31:0] rdata32, trap_pc32, ret_pc32;
   logic        trap_taken32, ret_taken32, wfi_stall32;
   fsm_state_e  fsm_state32;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        we;
      logic [2:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[15];

   csr_trap_unit dut (
      .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .mret(mret), .wfi(wfi), .pc(pc), .stall(stall),
      .retire(retire), .irq(irq), .ext_irq(ext_irq), .timer_irq(timer_irq),
      .csr_rdata(csr_rdata), .trap_taken(trap_taken), .ret_taken(ret_taken),
      .trap_pc(trap_pc), .ret_pc(ret_pc), .wfi_stall(wfi_stall), .fsm_state(fsm_state)
   );

   csr_trap_unit #(.CNT_W(32)) dut32 (
      .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .mret(mret), .wfi(wfi), .pc(pc), .stall(stall),
      .retire(retire), .irq(irq), .ext_irq(ext_irq), .timer_irq(timer_irq),
      .csr_rdata(rdata32), .trap_taken(trap_taken32), .ret_taken(ret_taken32),
      .trap_pc(trap_pc32), .ret_pc(ret_pc32), .wfi_stall(wfi_stall32), .fsm_state(fsm_state32)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; csr_we = 1'b0; csr_op = 3'b000; csr_addr = 12'h000; csr_wdata = 32'd0;
      mret = 1'b0; wfi = 1'b0; pc = 32'd0; stall = 1'b0; retire = 1'b0;
      irq = 4'd0; ext_irq = 1'b0; timer_irq = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic csr_write(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_we = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
      tick();
      csr_we = 1'b0; csr_wdata = 32'd0;
   endtask

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
      csr_addr = addr;
      #1;
      chk(name, csr_rdata, exp);
   endtask

   task automatic chk_rd32(input string name, input logic [11:0] addr, input logic [31:0] exp);
      csr_addr = addr;
      #1;
      chk(name, rdata32, exp);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 3'b001, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1888};
      tbl[1]  = '{1'b1, 3'b011, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_1880};
      tbl[2]  = '{1'b1, 3'b010, 12'h300, 32'h0000_0000, 1'b0, 32'h0000_1880};
      tbl[3]  = '{1'b1, 3'b001, 12'h304, 32'hFFFF_FFFF, 1'b0, 32'h000F_0880};
      tbl[4]  = '{1'b1, 3'b011, 12'h304, 32'h0008_0000, 1'b0, 32'h0007_0880};
      tbl[5]  = '{1'b1, 3'b001, 12'h305, 32'h1234_5677, 1'b0, 32'h1234_5675};
      tbl[6]  = '{1'b1, 3'b101, 12'h341, 32'h0000_001F, 1'b0, 32'h0000_001C};
      tbl[7]  = '{1'b1, 3'b110, 12'h341, 32'h0000_0003, 1'b0, 32'h0000_001C};
      tbl[8]  = '{1'b1, 3'b001, 12'h342, 32'h8000_000B, 1'b0, 32'h8000_000B};
      tbl[9]  = '{1'b1, 3'b111, 12'h342, 32'h0000_000B, 1'b0, 32'h8000_0000};
      tbl[10] = '{1'b1, 3'b001, 12'h342, 32'h0000_0005, 1'b1, 32'h8000_0000};
      tbl[11] = '{1'b1, 3'b001, 12'h344, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      tbl[12] = '{1'b1, 3'b001, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      tbl[13] = '{1'b1, 3'b000, 12'h341, 32'h0000_AAAA, 1'b0, 32'h0000_001C};
      tbl[14] = '{1'b1, 3'b010, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_1888};

      do_reset();
      chk("rst_trap_taken", {31'd0, trap_taken}, 32'd0);
      chk("rst_ret_taken", {31'd0, ret_taken}, 32'd0);
      chk("rst_wfi_stall", {31'd0, wfi_stall}, 32'd0);
      chk("rst_state", 32'(fsm_state), 32'(ST_RUN));
      chk_rd("rst_mstatus", 12'h300, 32'd0);
      chk_rd("rst_mie", 12'h304, 32'd0);
      chk_rd("rst_mtvec", 12'h305, 32'h0001_0000);
      chk_rd("rst_mepc", 12'h341, 32'd0);
      tick();
      chk_rd("rst_mcause", 12'h342, 32'd0);
      chk_rd("rst_minstret", 12'hB02, 32'd0);
      chk_rd("rst_minstreth", 12'hB82, 32'd0);

      for (int i = 0; i < 15; i++) begin
         csr_we = tbl[i].we; csr_op = tbl[i].op; csr_addr = tbl[i].addr;
         csr_wdata = tbl[i].wdata; stall = tbl[i].stall;
         tick();
         csr_we = 1'b0; csr_wdata = 32'd0; stall = 1'b0;
         chk_rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
      end

      // vectored local interrupt trap
      do_reset();
      csr_write(3'b001, 12'h305, 32'h0001_0001);
      csr_write(3'b001, 12'h304, 32'h0001_0000);
      pc = 32'h0000_0100; irq = 4'b0001;
      csr_write(3'b001, 12'h300, 32'h0000_0008);
      chk("loc_no_trap_yet", {31'd0, trap_taken}, 32'd0);
      tick();
      chk("loc_trap_taken", {31'd0, trap_taken}, 32'd1);
      chk("loc_trap_pc", trap_pc, 32'h0001_0040);
      chk_rd("loc_mepc", 12'h341, 32'h0000_0100);
      chk_rd("loc_mcause", 12'h342, 32'h8000_0010);
      chk_rd("loc_mstatus", 12'h300, 32'h0000_1880);
      irq = 4'd0;
      tick();
      chk("loc_pulse_end", {31'd0, trap_taken}, 32'd0);

      // ext beats timer, then mret
      do_reset();
      pc = 32'h0000_0200;
      csr_write(3'b001, 12'h304, 32'h0000_0880);
      ext_irq = 1'b1; timer_irq = 1'b1;
      csr_write(3'b001, 12'h300, 32'h0000_0008);
      tick();
      chk("prio_trap_taken", {31'd0, trap_taken}, 32'd1);
      chk("prio_trap_pc", trap_pc, 32'h0001_0000);
      chk_rd("prio_mcause", 12'h342, 32'h8000_000B);
      chk_rd("prio_mepc", 12'h341, 32'h0000_0200);
      ext_irq = 1'b0; timer_irq = 1'b0; mret = 1'b1;
      tick();
      mret = 1'b0;
      chk("mret_ret_taken", {31'd0, ret_taken}, 32'd1);
      chk("mret_ret_pc", ret_pc, 32'h0000_0200);
      chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);
      tick();
      chk("mret_pulse_end", {31'd0, ret_taken}, 32'd0);

      // wfi wait and wake without trap
      do_reset();
      csr_write(3'b001, 12'h304, 32'h0000_0800);
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk("wfi_stall_set", {31'd0, wfi_stall}, 32'd1);
      chk("wfi_state", 32'(fsm_state), 32'(ST_WAIT));
      tick();
      chk("wfi_stall_hold", {31'd0, wfi_stall}, 32'd1);
      ext_irq = 1'b1;
      tick();
      chk("wfi_wake", {31'd0, wfi_stall}, 32'd0);
      chk("wfi_no_trap", {31'd0, trap_taken}, 32'd0);
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk("wfi_pending_noop", {31'd0, wfi_stall}, 32'd0);
      ext_irq = 1'b0;
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk("wfi_reenter", {31'd0, wfi_stall}, 32'd1);
      rst = 1'b1; ext_irq = 1'b1;
      tick();
      rst = 1'b0; ext_irq = 1'b0;
      chk("wfi_rst_abort", {31'd0, wfi_stall}, 32'd0);
      chk("wfi_rst_state", 32'(fsm_state), 32'(ST_RUN));

      // reset during a trap cycle
      csr_write(3'b001, 12'h304, 32'h0000_0800);
      csr_write(3'b001, 12'h300, 32'h0000_0008);
      pc = 32'h0000_0300; ext_irq = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; ext_irq = 1'b0;
      chk("trap_rst_pulse", {31'd0, trap_taken}, 32'd0);
      chk_rd("trap_rst_mepc", 12'h341, 32'd0);
      tick();
      chk("trap_rst_after", {31'd0, trap_taken}, 32'd0);

      // counter wrap and write override
      do_reset();
      csr_write(3'b001, 12'hB00, 32'hFFFF_FFFF);
      csr_write(3'b001, 12'hB80, 32'hFFFF_FFFF);
      chk_rd("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
      chk_rd("cyc_hi_max", 12'hB80, 32'hFFFF_FFFF);
      chk_rd32("cyc32_hi", 12'hB80, 32'd0);
      chk_rd32("cyc32_lo_wrap", 12'hB00, 32'd0);
      tick();
      chk_rd("cyc_lo_wrap", 12'hB00, 32'd0);
      chk_rd("cyc_hi_wrap", 12'hB80, 32'd0);
      chk_rd32("cyc32_lo_next", 12'hB00, 32'd1);
      tick();
      chk_rd("cyc_lo_inc", 12'hB00, 32'd1);
      retire = 1'b1;
      csr_write(3'b001, 12'hB02, 32'd5);
      chk_rd("ins_override", 12'hB02, 32'd5);
      tick();
      chk_rd("ins_inc", 12'hB02, 32'd6);
      stall = 1'b1;
      tick();
      chk_rd("ins_stalled", 12'hB02, 32'd6);
      stall = 1'b0; retire = 1'b0;
      tick();
      chk_rd("ins_idle", 12'hB02, 32'd6);
      chk_rd("ins_hi", 12'hB82, 32'd0);

      // stall gating and trap priority over a CSR write
      do_reset();
      csr_write(3'b001, 12'h300, 32'h0000_0008);
      stall = 1'b1;
      csr_write(3'b010, 12'h300, 32'd0);
      stall = 1'b0;
      csr_write(3'b010, 12'h300, 32'd0);
      chk_rd("rs_zero_mstatus", 12'h300, 32'h0000_0008);
      stall = 1'b1;
      csr_write(3'b010, 12'h300, 32'h0000_0080);
      stall = 1'b0;
      chk_rd("stalled_write", 12'h300, 32'h0000_0008);
      csr_write(3'b001, 12'h304, 32'h0000_0800);
      ext_irq = 1'b1;
      csr_write(3'b001, 12'h304, 32'hFFFF_FFFF);
      chk("trapwin_taken", {31'd0, trap_taken}, 32'd1);
      chk_rd("trapwin_mie", 12'h304, 32'h0000_0800);
      ext_irq = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 4, range 1..16: number of local interrupt sources.
REQ-002 The block SHALL have parameter CNT_W, default 64, allowed 32 or 64: counter width.
REQ-003 The block SHALL have parameter MTVEC_RST, default 32'h0001_0000: reset trap vector.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 csr_we  in  1  CSR instruction valid this cycle.
REQ-008 csr_op  in  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-009 csr_addr  in  12  CSR address.
REQ-010 csr_wdata  in  32  rs1 value or zero-extended zimm, pre-selected.
REQ-011 mret / wfi  in  1 each  decoded instruction valid.
REQ-012 pc  in  32  PC of the current instruction.
REQ-013 stall  in  1  pipeline stall (IM or DM); high blocks all commits.
REQ-014 retire  in  1  instruction retires this cycle.
REQ-015 irq  in  NUM_IRQ  level local interrupts; ext_irq, timer_irq  in  1 each, level.
REQ-016 csr_rdata  out  32  combinational read data.
REQ-017 trap_taken / ret_taken  out  1 each  one-cycle redirect pulses.
REQ-018 trap_pc / ret_pc  out  32  redirect targets; wfi_stall  out  1  hold fetch.

Function
REQ-019 CSR map SHALL be: 300 mstatus, 304 mie, 305 mtvec, 341 mepc, 342 mcause, 344 mip (read-only), B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi; other addresses read 0, writes ignored.
REQ-020 mstatus SHALL implement only MIE[3], MPIE[7], MPP[12:11]; other bits read 0.
REQ-021 mie SHALL implement MTIE[7], MEIE[11], local enables [16+i]; mip SHALL reflect timer_irq[7], ext_irq[11], irq[i][16+i] combinationally.
REQ-022 RS/RC/RSI/RCI with csr_wdata==0 SHALL NOT write; writes commit only when csr_we & ~stall.
REQ-023 mepc[1:0] SHALL read 0; mtvec[1] SHALL read 0; mtvec[0] selects vectored mode.
REQ-024 An interrupt is pending when |(mie & mip); priority SHALL be ext (cause 11) > timer (7) > local lowest index (16+i), via a fixed priority encoder.
REQ-025 A trap SHALL be taken in the cycle where pending & mstatus.MIE & ~stall: trap_taken=1, mepc<=pc, mcause<={1'b1,cause}, MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-026 trap_pc SHALL be {mtvec[31:2],2'b00} in direct mode, that base + 4*cause in vectored mode.
REQ-027 A trap in the same cycle as csr_we, mret or wfi SHALL win; that instruction SHALL NOT commit.
REQ-028 mret & ~stall SHALL pulse ret_taken with ret_pc=mepc, set MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-029 FSM states RUN, WAIT: RUN->WAIT on wfi & ~stall & ~pending; wfi with pending SHALL be a no-op; WAIT->RUN when pending regardless of MIE; wfi_stall=1 only in WAIT.
REQ-030 mcycle SHALL increment every cycle; minstret SHALL increment on retire & ~stall; both wrap at 2^CNT_W-1 to 0.
REQ-031 A CSR write to a counter half SHALL override that cycle's increment; with CNT_W=32, hi halves read 0 and ignore writes.

Reset
REQ-032 On rst: mstatus, mie, mepc, mcause, counters = 0; mtvec = MTVEC_RST; FSM = RUN; trap_taken, ret_taken, wfi_stall = 0.
REQ-033 rst mid-WAIT or in a trap cycle SHALL abort it; no redirect pulse follows.

Structure
REQ-034 Package csr_trap_pkg SHALL hold CSR addresses, bit positions, cause codes, the csr_op enum and the FSM state enum.
REQ-035 Sub-module csr_irq_arb (NUM_IRQ-parameterised priority encoder: pending, cause) SHALL be instantiated once.

Verification
REQ-036 mtvec=0x0001_0001, mie=0x0001_0000, MIE=1, irq[0]=1 at pc=0x100 -> trap_taken, trap_pc=0x0001_0040, mepc=0x100, mcause=0x8000_0010.
REQ-037 ext_irq and timer_irq together, both enabled -> mcause=0x8000_000B; after mret, ret_pc=mepc and MIE=1.
REQ-038 wfi with nothing pending -> wfi_stall=1; ext_irq with MIE=0 -> wfi_stall=0 next cycle, no trap_taken.
REQ-039 Preload mcycle={0xFFFF_FFFF,0xFFFF_FFFF} -> reads 0 one cycle later; CNT_W=32 read of B80 -> 0.
REQ-040 CSRRS mstatus with wdata=0 while stall=1 then stall=0 -> mstatus unchanged; trap concurrent with CSRRW mie -> mie unchanged.
